// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: prioritised stall/flush/PC sequencer for the 5-stage pipeline
// Inputs  : decode hazards (stall_fetch/stall_decode/halt/illegal_opcode_exception/return_in_pipeline/
//           take_branch_target), ret_addr_valid from the call stack, resume and exc_ack from the host.
// Outputs : pc_en/pc_sel, per-register enables and flushes, state_out and exc_cause for debug,
//           saturating stall_count of cycles with pc_en low.
module pipeline_hazard_controller #(
  parameter int RET_TIMEOUT  = 15,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clock_i,
  input  logic                 nreset_i,
  input  logic                 stall_fetch_i,
  input  logic                 stall_decode_i,
  input  logic                 halt_i,
  input  logic                 illegal_opcode_exception_i,
  input  logic                 return_in_pipeline_i,
  input  logic                 take_branch_target_i,
  input  logic                 ret_addr_valid_i,
  input  logic                 resume_i,
  input  logic                 exc_ack_i,
  output logic                 pc_en_o,
  output logic [1:0]           pc_sel_o,
  output logic                 if_id_en_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_en_o,
  output logic                 id_ex_flush_o,
  output logic                 ex_mem_en_o,
  output logic                 mem_wb_en_o,
  output logic [2:0]           state_out_o,
  output logic [1:0]           exc_cause_o,
  output logic [CNT_WIDTH-1:0] stall_count_o
);
  typedef enum logic [2:0] {RUN = 3'd0, RET_WAIT = 3'd1, DRAIN = 3'd2, HALTED = 3'd3, EXCEPTION = 3'd4} state_e;
  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [1:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] stall_q;
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cause_d       = cause_q;
    pc_en_o       = 1'b1;
    pc_sel_o      = 2'b00;
    if_id_en_o    = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_en_o    = 1'b1;
    id_ex_flush_o = 1'b0;
    ex_mem_en_o   = 1'b1;
    mem_wb_en_o   = 1'b1;
    case (state_q)
      RUN: begin
        if (illegal_opcode_exception_i) begin
          pc_en_o       = 1'b0;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          cause_d       = 2'b01;
          state_d       = EXCEPTION;
        end else if (halt_i) begin
          pc_en_o       = 1'b0;
          if_id_flush_o = 1'b1;
          cnt_d         = '0;
          state_d       = DRAIN;
        end else if (return_in_pipeline_i) begin
          pc_en_o       = 1'b0;
          if_id_flush_o = 1'b1;
          cnt_d         = '0;
          state_d       = RET_WAIT;
        end else if (stall_decode_i) begin
          // branch operands are not valid under a load-use stall, so a taken branch is dropped
          pc_en_o       = 1'b0;
          if_id_en_o    = 1'b0;
          id_ex_flush_o = 1'b1;
        end else if (take_branch_target_i) begin
          pc_sel_o      = 2'b01;
          if_id_flush_o = 1'b1;
        end else if (stall_fetch_i) begin
          pc_en_o       = 1'b0;
          if_id_flush_o = 1'b1;
        end
      end
      RET_WAIT: begin
        if_id_flush_o = 1'b1;
        if (ret_addr_valid_i) begin
          pc_sel_o = 2'b10;
          state_d  = RUN;
        end else begin
          pc_en_o = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == 8'(RET_TIMEOUT - 1)) begin
            cause_d = 2'b10;
            state_d = EXCEPTION;
          end
        end
      end
      DRAIN: begin
        pc_en_o       = 1'b0;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
        cnt_d         = cnt_q + 8'd1;
        state_d       = cnt_q == 8'(DRAIN_CYCLES - 1) ? HALTED : DRAIN;
      end
      HALTED: begin
        pc_en_o     = 1'b0;
        if_id_en_o  = 1'b0;
        id_ex_en_o  = 1'b0;
        ex_mem_en_o = 1'b0;
        mem_wb_en_o = 1'b0;
        state_d     = resume_i ? RUN : HALTED;
      end
      EXCEPTION: begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
        pc_en_o       = exc_ack_i;
        pc_sel_o      = exc_ack_i ? 2'b11 : 2'b00;
        cause_d       = exc_ack_i ? 2'b00 : cause_q;
        state_d       = exc_ack_i ? RUN : EXCEPTION;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      cause_q <= 2'b00;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      if (!pc_en_o && stall_q != '1) stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end
  assign state_out_o   = state_q;
  assign exc_cause_o   = cause_q;
  assign stall_count_o = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: scoreboard bench with a behavioural model of the hazard sequencer
module tb_pipeline_hazard_controller;
  localparam int RT = 15;
  localparam int DC = 3;
  localparam int CW = 6;
  localparam int SAT = (1 << CW) - 1;
  localparam logic [8:0] SF = 9'h100, SD = 9'h080, HLT = 9'h040, ILL = 9'h020, RET = 9'h010,
                         TB = 9'h008, VLD = 9'h004, RES = 9'h002, ACK = 9'h001;
  logic clk = 1'b0, nreset = 1'b0;
  logic sf = 0, sd = 0, hlt = 0, ill = 0, ret = 0, tb = 0, vld = 0, res = 0, ack = 0;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic [1:0] pc_sel, exc_cause;
  logic [2:0] state_out;
  logic [CW-1:0] stall_count;
  logic [19:0] exp_q[$];
  int errors = 0, checks = 0;
  int m_mode, m_wait, m_drain, m_stalls;
  logic [1:0] m_cause;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.RET_TIMEOUT(RT), .DRAIN_CYCLES(DC), .CNT_WIDTH(CW)) dut (
    .clock_i(clk), .nreset_i(nreset),
    .stall_fetch_i(sf), .stall_decode_i(sd), .halt_i(hlt), .illegal_opcode_exception_i(ill),
    .return_in_pipeline_i(ret), .take_branch_target_i(tb), .ret_addr_valid_i(vld),
    .resume_i(res), .exc_ack_i(ack),
    .pc_en_o(pc_en), .pc_sel_o(pc_sel), .if_id_en_o(if_id_en), .if_id_flush_o(if_id_flush),
    .id_ex_en_o(id_ex_en), .id_ex_flush_o(id_ex_flush), .ex_mem_en_o(ex_mem_en),
    .mem_wb_en_o(mem_wb_en), .state_out_o(state_out), .exc_cause_o(exc_cause),
    .stall_count_o(stall_count)
  );

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_drain = 0; m_stalls = 0; m_cause = 2'b00;
  endtask

  // modes: 0 run, 1 waiting for return address, 2 draining, 3 halted, 4 exception
  task automatic model_step(input logic [8:0] v, output logic [19:0] e);
    logic pe, ie, ifl, de, dfl, xe, we;
    logic [1:0] sel;
    int old_mode;
    logic [1:0] old_cause;
    int old_stalls;
    old_mode = m_mode; old_cause = m_cause; old_stalls = m_stalls;
    pe = 1; sel = 0; ie = 1; ifl = 0; de = 1; dfl = 0; xe = 1; we = 1;
    if (old_mode == 0) begin
      if (v & ILL) begin pe = 0; ifl = 1; dfl = 1; m_cause = 2'b01; m_mode = 4; end
      else if (v & HLT) begin pe = 0; ifl = 1; m_drain = 0; m_mode = 2; end
      else if (v & RET) begin pe = 0; ifl = 1; m_wait = 0; m_mode = 1; end
      else if (v & SD) begin pe = 0; ie = 0; dfl = 1; end
      else if (v & TB) begin sel = 2'b01; ifl = 1; end
      else if (v & SF) begin pe = 0; ifl = 1; end
    end else if (old_mode == 1) begin
      ifl = 1;
      if (v & VLD) begin sel = 2'b10; m_mode = 0; end
      else begin
        pe = 0; m_wait++;
        if (m_wait == RT) begin m_cause = 2'b10; m_mode = 4; end
      end
    end else if (old_mode == 2) begin
      pe = 0; ifl = 1; dfl = 1; m_drain++;
      if (m_drain == DC) m_mode = 3;
    end else if (old_mode == 3) begin
      pe = 0; ie = 0; de = 0; xe = 0; we = 0;
      if (v & RES) m_mode = 0;
    end else begin
      ifl = 1; dfl = 1; pe = 0;
      if (v & ACK) begin pe = 1; sel = 2'b11; m_cause = 2'b00; m_mode = 0; end
    end
    e = {pe, sel, ie, ifl, de, dfl, xe, we, 3'(old_mode), old_cause, CW'(old_stalls)};
    if (!pe && m_stalls < SAT) m_stalls++;
  endtask

  task automatic apply(input logic [8:0] v);
    {sf, sd, hlt, ill, ret, tb, vld, res, ack} = v;
  endtask

  task automatic drive(input logic [8:0] v);
    logic [19:0] e;
    @(posedge clk);
    #1;
    nreset = 1'b1;
    apply(v);
    model_step(v, e);
    exp_q.push_back(e);
  endtask

  // reset lands mid-cycle so the sampled values show the asynchronous effect
  task automatic do_reset();
    logic [19:0] e;
    @(posedge clk);
    #1;
    apply(9'h000);
    nreset = 1'b0;
    model_reset();
    model_step(9'h000, e);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [19:0] e, a;
      e = exp_q.pop_front();
      a = {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en,
           state_out, exc_cause, stall_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t actual{pc_en,sel,ifen,iff,iden,idf,exen,wben,st,cause,cnt}=%b_%b_%b%b%b%b%b%b_%0d_%b_%0d required=%b_%b_%b%b%b%b%b%b_%0d_%b_%0d",
                 $time, a[19], a[18:17], a[16], a[15], a[14], a[13], a[12], a[11], a[10:8], a[7:6], a[5:0],
                 e[19], e[18:17], e[16], e[15], e[14], e[13], e[12], e[11], e[10:8], e[7:6], e[5:0]);
      end
    end
  end

  initial begin
    logic [8:0] v;
    model_reset();
    repeat (2) @(posedge clk);
    repeat (5) drive(9'h000);
    drive(SD | TB); drive(TB); drive(9'h000);
    do_reset();
    drive(RET); repeat (4) drive(9'h000); drive(VLD); drive(9'h000);
    do_reset();
    drive(RET); repeat (RT) drive(9'h000); drive(9'h000); drive(ACK); drive(9'h000);
    drive(RET); repeat (RT - 1) drive(9'h000); drive(VLD); drive(9'h000);
    do_reset();
    drive(HLT | ILL); drive(9'h000); drive(ACK); drive(9'h000);
    drive(HLT); drive(RES); drive(9'h000); drive(9'h000); drive(9'h000); drive(RES); drive(9'h000);
    drive(HLT); repeat (DC + 2) drive(9'h000);
    do_reset(); drive(9'h000);
    drive(HLT); repeat (SAT + 8) drive(SD | TB | ILL); drive(RES); drive(9'h000);
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else begin
        v = 9'h000;
        if ($urandom_range(0, 3) == 0) v |= SF;
        if ($urandom_range(0, 3) == 0) v |= SD;
        if ($urandom_range(0, 15) == 0) v |= HLT;
        if ($urandom_range(0, 15) == 0) v |= ILL;
        if ($urandom_range(0, 7) == 0) v |= RET;
        if ($urandom_range(0, 3) == 0) v |= TB;
        if ($urandom_range(0, 11) == 0) v |= VLD;
        if ($urandom_range(0, 5) == 0) v |= RES;
        if ($urandom_range(0, 5) == 0) v |= ACK;
        drive(v);
      end
    end
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
